// File: rtl/rx_segment_splitter_ble.sv
// rx_segment_splitter_ble: splits an intermediate-RAM sample stream into header and payload sections
// Ports: clk, reset (async active-low), valid_in/data_in sample strobe and word,
//   header_count/payload_count section lengths (latched at frame start),
//   data_out/hdr_valid/pld_valid/sample_index registered sample, section strobe and index,
//   frame_done pulse with the last sample, len_error sticky watchdog flag.
// Optional: define RX_LEN_CHECK_EN to enable the GAP_MAX idle-cycle watchdog.
module rx_segment_splitter_ble #(
  parameter int DATA    = 12,
  parameter int CW      = 12,
  parameter int GAP_MAX = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [DATA-1:0] data_in,
  input  logic [CW-1:0]   header_count,
  input  logic [CW-1:0]   payload_count,
  output logic [DATA-1:0] data_out,
  output logic            hdr_valid,
  output logic            pld_valid,
  output logic [CW-1:0]   sample_index,
  output logic            frame_done,
  output logic            len_error
);
  typedef enum logic [1:0] {IDLE, HEADER, GAP, PAYLOAD} state_t;
  localparam logic [CW-1:0] ONE = CW'(1);
  state_t          state_q, state_d;
  logic [CW-1:0]   hc_q, hc_d, pc_q, pc_d;
  logic [CW-1:0]   hdr_cnt_q, hdr_cnt_d, pld_cnt_q, pld_cnt_d;
  logic [CW-1:0]   sample_index_q, sample_index_d;
  logic [DATA-1:0] data_out_q, data_out_d;
  logic            hdr_valid_q, hdr_valid_d, pld_valid_q, pld_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            len_error_q, len_error_d;
`ifdef RX_LEN_CHECK_EN
  localparam int IW = $clog2(GAP_MAX + 1);
  logic [IW-1:0]   idle_q, idle_d;
`endif
  always_comb begin
    state_d        = state_q;
    hc_d           = hc_q;
    pc_d           = pc_q;
    hdr_cnt_d      = hdr_cnt_q;
    pld_cnt_d      = pld_cnt_q;
    sample_index_d = sample_index_q;
    data_out_d     = data_out_q;
    hdr_valid_d    = 1'b0;
    pld_valid_d    = 1'b0;
    frame_done_d   = 1'b0;
    len_error_d    = len_error_q;
    unique case (state_q)
      IDLE: if (valid_in) begin
        hc_d        = header_count;
        pc_d        = payload_count;
        len_error_d = 1'b0;
        if (header_count != '0) begin
          data_out_d     = data_in;
          hdr_valid_d    = 1'b1;
          sample_index_d = '0;
          hdr_cnt_d      = ONE;
          frame_done_d   = header_count == ONE && payload_count == '0;
          state_d        = header_count != ONE ? HEADER : payload_count == '0 ? IDLE : GAP;
        end else if (payload_count != '0) begin
          data_out_d     = data_in;
          pld_valid_d    = 1'b1;
          sample_index_d = '0;
          pld_cnt_d      = ONE;
          frame_done_d   = payload_count == ONE;
          state_d        = payload_count == ONE ? IDLE : PAYLOAD;
        end
      end
      HEADER: if (valid_in) begin
        data_out_d     = data_in;
        hdr_valid_d    = 1'b1;
        sample_index_d = hdr_cnt_q;
        hdr_cnt_d      = hdr_cnt_q + ONE;
        frame_done_d   = hdr_cnt_q == hc_q - ONE && pc_q == '0;
        state_d        = hdr_cnt_q != hc_q - ONE ? HEADER : pc_q == '0 ? IDLE : GAP;
      end
      GAP: if (valid_in) begin
        data_out_d     = data_in;
        pld_valid_d    = 1'b1;
        sample_index_d = '0;
        pld_cnt_d      = ONE;
        frame_done_d   = pc_q == ONE;
        state_d        = pc_q == ONE ? IDLE : PAYLOAD;
      end
      PAYLOAD: if (valid_in) begin
        data_out_d     = data_in;
        pld_valid_d    = 1'b1;
        sample_index_d = pld_cnt_q;
        pld_cnt_d      = pld_cnt_q + ONE;
        frame_done_d   = pld_cnt_q == pc_q - ONE;
        state_d        = pld_cnt_q == pc_q - ONE ? IDLE : PAYLOAD;
      end
      default: state_d = IDLE;
    endcase
`ifdef RX_LEN_CHECK_EN
    // Watchdog: consecutive idle cycles inside a frame abort it without frame_done.
    idle_d = '0;
    if (state_q != IDLE && !valid_in) begin
      idle_d = idle_q + IW'(1);
      if (idle_q == IW'(GAP_MAX - 1)) begin
        idle_d      = '0;
        len_error_d = 1'b1;
        state_d     = IDLE;
      end
    end
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      hc_q           <= '0;
      pc_q           <= '0;
      hdr_cnt_q      <= '0;
      pld_cnt_q      <= '0;
      sample_index_q <= '0;
      data_out_q     <= '0;
      hdr_valid_q    <= 1'b0;
      pld_valid_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      len_error_q    <= 1'b0;
`ifdef RX_LEN_CHECK_EN
      idle_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      hc_q           <= hc_d;
      pc_q           <= pc_d;
      hdr_cnt_q      <= hdr_cnt_d;
      pld_cnt_q      <= pld_cnt_d;
      sample_index_q <= sample_index_d;
      data_out_q     <= data_out_d;
      hdr_valid_q    <= hdr_valid_d;
      pld_valid_q    <= pld_valid_d;
      frame_done_q   <= frame_done_d;
      len_error_q    <= len_error_d;
`ifdef RX_LEN_CHECK_EN
      idle_q         <= idle_d;
`endif
    end
  end
  assign data_out     = data_out_q;
  assign hdr_valid    = hdr_valid_q;
  assign pld_valid    = pld_valid_q;
  assign sample_index = sample_index_q;
  assign frame_done   = frame_done_q;
`ifdef RX_LEN_CHECK_EN
  assign len_error    = len_error_q;
`else
  assign len_error    = 1'b0;
`endif
endmodule

// File: tb/tb_rx_segment_splitter_ble.sv
// tb_rx_segment_splitter_ble: directed self-checking bench for rx_segment_splitter_ble
module tb_rx_segment_splitter_ble;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] data_in = '0;
  logic [11:0] header_count = '0;
  logic [11:0] payload_count = '0;
  logic [11:0] data_out;
  logic        hdr_valid, pld_valid, frame_done, len_error;
  logic [11:0] sample_index;
  int checks = 0;
  int failures = 0;
  rx_segment_splitter_ble #(.DATA(12), .CW(12), .GAP_MAX(64)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .header_count(header_count), .payload_count(payload_count),
    .data_out(data_out), .hdr_valid(hdr_valid), .pld_valid(pld_valid),
    .sample_index(sample_index), .frame_done(frame_done), .len_error(len_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic h, input logic p, input logic dn,
                         input logic [11:0] idx, input logic [11:0] d);
    chk(tag, {3'b0, h, p, dn, idx, 2'b0, d}, {3'b0, h, p, dn, idx, 2'b0, d});
  endtask
  task automatic chk_vec(input string tag, input logic h, input logic p, input logic dn,
                         input logic [11:0] idx, input logic [11:0] d);
    chk(tag, {3'b0, hdr_valid, pld_valid, frame_done, sample_index, 2'b0, data_out},
             {3'b0, h, p, dn, idx, 2'b0, d});
  endtask
  task automatic step(input logic v, input logic [11:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_quiet(input string tag, input logic [11:0] d);
    chk(tag, {16'b0, 3'b0, hdr_valid, pld_valid, frame_done, data_out},
             {16'b0, 3'b0, 3'b000, d});
  endtask
  initial begin
    #3;
    chk_vec("reset_outputs", 1'b0, 1'b0, 1'b0, 12'd0, 12'h000);
    chk("reset_len_error", {31'b0, len_error}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Frame 1: hc=4, pc=6 with a 17-cycle gap
    header_count = 12'd4;
    payload_count = 12'd6;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 12'h001 + 12'(i));
      chk_vec("f1_hdr", 1'b1, 1'b0, 1'b0, 12'(i), 12'h001 + 12'(i));
    end
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 12'hfff);
      chk_quiet("f1_gap", 12'h004);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 12'h101 + 12'(i));
      chk_vec("f1_pld", 1'b0, 1'b1, i == 5, 12'(i), 12'h101 + 12'(i));
    end
    step(1'b0, 12'h000);
    chk_quiet("f1_after", 12'h106);
    chk("f1_len_error", {31'b0, len_error}, 32'd0);
    // Back-to-back frames hc=3, pc=2 with no gap
    header_count = 12'd3;
    payload_count = 12'd2;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 12'h200 + 12'(i));
      chk_vec("b2b", (i % 5) < 3, (i % 5) >= 3, (i % 5) == 4,
              (i % 5) < 3 ? 12'(i % 5) : 12'((i % 5) - 3), 12'h200 + 12'(i));
    end
    step(1'b0, 12'h000);
    chk_quiet("b2b_after", 12'h209);
    // hc=0, pc=3: payload only
    header_count = 12'd0;
    payload_count = 12'd3;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 12'h300 + 12'(i));
      chk_vec("pld_only", 1'b0, 1'b1, i == 2, 12'(i), 12'h300 + 12'(i));
    end
    // hc=2, pc=0: header only
    header_count = 12'd2;
    payload_count = 12'd0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 12'h400 + 12'(i));
      chk_vec("hdr_only", 1'b1, 1'b0, i == 1, 12'(i), 12'h400 + 12'(i));
    end
    // hc=0, pc=0: sample dropped, data_out holds
    header_count = 12'd0;
    payload_count = 12'd0;
    step(1'b1, 12'h4aa);
    chk_quiet("empty_frame", 12'h401);
    step(1'b0, 12'h000);
    chk_quiet("empty_frame_after", 12'h401);
    // Count change mid-frame ignored: hc 4 -> 9 after first sample, pc=2
    header_count = 12'd4;
    payload_count = 12'd2;
    step(1'b1, 12'h500);
    chk_vec("latch_hdr0", 1'b1, 1'b0, 1'b0, 12'd0, 12'h500);
    header_count = 12'd9;
    payload_count = 12'd7;
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 12'h500 + 12'(i));
      chk_vec("latch_hdr", 1'b1, 1'b0, 1'b0, 12'(i), 12'h500 + 12'(i));
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 12'h510 + 12'(i));
      chk_vec("latch_pld", 1'b0, 1'b1, i == 1, 12'(i), 12'h510 + 12'(i));
    end
    // Reset during payload sample 3 of 6
    header_count = 12'd2;
    payload_count = 12'd6;
    step(1'b1, 12'h600);
    step(1'b1, 12'h601);
    chk_vec("rst_hdr1", 1'b1, 1'b0, 1'b0, 12'd1, 12'h601);
    step(1'b1, 12'h610);
    step(1'b1, 12'h611);
    chk_vec("rst_pld1", 1'b0, 1'b1, 1'b0, 12'd1, 12'h611);
    valid_in = 1'b1;
    data_in = 12'h612;
    #2;
    reset = 1'b0;
    #1;
    chk_vec("rst_async", 1'b0, 1'b0, 1'b0, 12'd0, 12'h000);
    @(posedge clk);
    #1;
    chk_vec("rst_held", 1'b0, 1'b0, 1'b0, 12'd0, 12'h000);
    valid_in = 1'b0;
    reset = 1'b1;
    header_count = 12'd1;
    payload_count = 12'd1;
    step(1'b1, 12'h700);
    chk_vec("post_rst_hdr", 1'b1, 1'b0, 1'b0, 12'd0, 12'h700);
    step(1'b1, 12'h701);
    chk_vec("post_rst_pld", 1'b0, 1'b1, 1'b1, 12'd0, 12'h701);
    // Stream stalls after header for 64 idle cycles
    header_count = 12'd4;
    payload_count = 12'd6;
    for (int i = 0; i < 4; i++) step(1'b1, 12'h800 + 12'(i));
    chk_vec("wd_hdr_last", 1'b1, 1'b0, 1'b0, 12'd3, 12'h803);
    for (int i = 0; i < 63; i++) step(1'b0, 12'h000);
    chk("wd_63_idle", {31'b0, len_error}, 32'd0);
    step(1'b0, 12'h000);
`ifdef RX_LEN_CHECK_EN
    chk("wd_64_idle", {31'b0, len_error}, 32'd1);
    chk_quiet("wd_no_done", 12'h803);
    step(1'b0, 12'h000);
    chk("wd_sticky", {31'b0, len_error}, 32'd1);
    header_count = 12'd1;
    payload_count = 12'd1;
    step(1'b1, 12'h900);
    chk_vec("wd_restart", 1'b1, 1'b0, 1'b0, 12'd0, 12'h900);
    chk("wd_cleared", {31'b0, len_error}, 32'd0);
`else
    chk("wd_disabled", {31'b0, len_error}, 32'd0);
    chk_quiet("wd_disabled_wait", 12'h803);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 12'h900 + 12'(i));
      chk_vec("wd_disabled_pld", 1'b0, 1'b1, i == 5, 12'(i), 12'h900 + 12'(i));
    end
    chk("wd_disabled_end", {31'b0, len_error}, 32'd0);
`endif
    step(1'b0, 12'h000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
